// File: rtl/stdp_learn_ctrl_pkg.sv
// Shared types and helpers for the STDP learning controller.
// Weight arithmetic runs on int so that the saturation compares cannot wrap.
package stdp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic int trace_max(input int tr_width);
    return (1 << tr_width) - 1;
  endfunction

  function automatic int sat_inc(input int w, input int w_width);
    int w_max;
    w_max = (1 << w_width) - 1;
    return (w >= w_max) ? w_max : w + 1;
  endfunction

  function automatic int sat_dec(input int w);
    return (w <= 0) ? 0 : w - 1;
  endfunction

endpackage

// File: rtl/stdp_learn_ctrl_if.sv
// Read-modify-write port between the learning controller and the weight store.
// Read data is expected one cycle after the address is presented.
interface stdp_learn_ctrl_if #(
  parameter int N_SYN   = 8,
  parameter int W_WIDTH = 4
);
  localparam int IDX_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;

  logic [IDX_W-1:0]   w_addr;
  logic               w_wr_en;
  logic [W_WIDTH-1:0] w_wr_data;
  logic [W_WIDTH-1:0] w_rd_data;

  modport master (
    output w_addr,
    output w_wr_en,
    output w_wr_data,
    input  w_rd_data
  );

  modport slave (
    input  w_addr,
    input  w_wr_en,
    input  w_wr_data,
    output w_rd_data
  );

endinterface

// File: rtl/stdp_learn_ctrl_tick_gen.sv
// Time-step divider: one-cycle tick every TICK_COUNT enabled cycles.
module stdp_tick_gen #(
  parameter logic [23:0] TICK_COUNT = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ena,
  output logic o_tick
);

  logic [23:0] r_cnt;
  logic        w_last;

  assign w_last = (r_cnt == (TICK_COUNT - 24'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_ena) begin
      r_cnt <= w_last ? '0 : r_cnt + 24'd1;
    end
  end

  // Gated by enable so a frozen counter parked on the last value stays silent.
  assign o_tick = i_ena & w_last;

endmodule

// File: rtl/stdp_learn_ctrl.sv
// STDP learning controller: per-input traces, post-spike pending flag and a
// read-modify-write sweep over all synapse weights.
module stdp_learn_ctrl
  import stdp_pkg::*;
#(
  parameter int          N_SYN      = 8,
  parameter int          W_WIDTH    = 4,
  parameter int          TR_WIDTH   = 3,
  parameter logic [23:0] TICK_COUNT = 24'd10_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_ena,
  input  logic               i_learn_en,
  input  logic [N_SYN-1:0]   i_pre_spike,
  input  logic               i_post_spike,
  stdp_learn_ctrl_if.master  wbus,
  output logic               o_busy,
  output logic               o_tick
);

  localparam int                  IDX_W     = (N_SYN > 1) ? $clog2(N_SYN) : 1;
  localparam logic [TR_WIDTH-1:0] TRACE_MAX = TR_WIDTH'(trace_max(TR_WIDTH));
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_SYN - 1);

  logic                w_tick;
  logic [TR_WIDTH-1:0] r_trace [N_SYN];
  logic [N_SYN-1:0]    r_snap_live;
  logic                r_post_pending;
  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_start;

  stdp_tick_gen #(
    .TICK_COUNT(TICK_COUNT)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ena (i_ena),
    .o_tick(w_tick)
  );

  assign o_tick = w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SYN; i++) r_trace[i] <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < N_SYN; i++) begin
        if (i_pre_spike[i])        r_trace[i] <= TRACE_MAX;
        else if (r_trace[i] != '0) r_trace[i] <= r_trace[i] - 1'b1;
      end
    end
  end

  // A spike arriving in the same cycle a sweep starts keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_post_pending <= 1'b0;
    end else if (i_post_spike && i_ena) begin
      r_post_pending <= 1'b1;
    end else if (w_start) begin
      r_post_pending <= 1'b0;
    end
  end

  // The sweep only needs to know which traces were live when it began.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_snap_live <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_start) begin
        for (int i = 0; i < N_SYN; i++) r_snap_live[i] <= (r_trace[i] != '0);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_start        = 1'b0;
    wbus.w_addr    = '0;
    wbus.w_wr_en   = 1'b0;
    wbus.w_wr_data = '0;
    o_busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_post_pending && i_learn_en && i_ena) begin
          w_start     = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = READ;
        end
      end
      READ: begin
        o_busy      = 1'b1;
        wbus.w_addr = r_idx;
        w_state_nxt = WRITE;
      end
      WRITE: begin
        o_busy       = 1'b1;
        wbus.w_addr  = r_idx;
        wbus.w_wr_en = 1'b1;
        if (r_snap_live[r_idx]) begin
          wbus.w_wr_data = W_WIDTH'(sat_inc(int'(wbus.w_rd_data), W_WIDTH));
        end else begin
          wbus.w_wr_data = W_WIDTH'(sat_dec(int'(wbus.w_rd_data)));
        end
        if (r_idx == LAST_IDX) begin
          w_state_nxt = IDLE;
        end else begin
          w_idx_nxt   = r_idx + 1'b1;
          w_state_nxt = READ;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stdp_learn_ctrl.sv
// Directed bench for stdp_learn_ctrl with a behavioural weight store
// and a short time step so that trace decay is reachable quickly.
module tb_stdp_learn_ctrl;

  localparam int          N_SYN      = 8;
  localparam int          W_WIDTH    = 4;
  localparam int          TR_WIDTH   = 3;
  localparam logic [23:0] TICK_COUNT = 24'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       learnEn = 1'b0;
  logic [7:0] preSpike = 8'd0;
  logic       postSpike = 1'b0;
  logic       busy;
  logic       tick;

  stdp_learn_ctrl_if #(.N_SYN(N_SYN), .W_WIDTH(W_WIDTH)) wbus ();

  stdp_learn_ctrl #(
    .N_SYN     (N_SYN),
    .W_WIDTH   (W_WIDTH),
    .TR_WIDTH  (TR_WIDTH),
    .TICK_COUNT(TICK_COUNT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ena       (ena),
    .i_learn_en  (learnEn),
    .i_pre_spike (preSpike),
    .i_post_spike(postSpike),
    .wbus        (wbus.master),
    .o_busy      (busy),
    .o_tick      (tick)
  );

  always #5 clk = ~clk;

  // Weight store: registered read, DUT write port plus a bench-side preload port.
  logic [3:0] mem [8];
  logic       bdEn = 1'b0;
  logic [2:0] bdAddr = 3'd0;
  logic [3:0] bdData = 4'd0;

  always @(posedge clk) begin
    wbus.w_rd_data <= mem[wbus.w_addr];
    if (wbus.w_wr_en) mem[wbus.w_addr] <= wbus.w_wr_data;
    if (bdEn) mem[bdAddr] <= bdData;
  end

  // Write log and activity counters, sampled on the falling edge.
  int         cyc = 0;
  int         busyCnt = 0;
  int         tickCnt = 0;
  logic [2:0] wrAddr[$];
  logic [3:0] wrData[$];
  int         wrCyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wbus.w_wr_en) begin
      wrAddr.push_back(wbus.w_addr);
      wrData.push_back(wbus.w_wr_data);
      wrCyc.push_back(cyc);
    end
    if (busy) busyCnt++;
    if (tick) tickCnt++;
  end

  int errors = 0;
  int checks = 0;
  int postCyc = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Single-cycle post-spike pulse, launched from a falling edge.
  task automatic applyStimulus();
    postSpike = 1'b1;
    postCyc   = cyc;
    @(negedge clk);
    postSpike = 1'b0;
  endtask

  task automatic setWeight(input logic [2:0] a, input logic [3:0] d);
    bdEn   = 1'b1;
    bdAddr = a;
    bdData = d;
    @(negedge clk);
    bdEn = 1'b0;
  endtask

  // Returns on the falling edge just before the edge that applies the tick.
  task automatic waitTick();
    int n;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (tick) break;
      n++;
    end
    checkOutput("tick_seen", {31'd0, tick}, 32'd1);
  endtask

  task automatic applyTickSpikes(input logic [7:0] pre);
    waitTick();
    preSpike = pre;
    @(negedge clk);
    preSpike = 8'd0;
  endtask

  task automatic passTicks(input int n);
    repeat (n) begin
      waitTick();
      @(negedge clk);
    end
  endtask

  task automatic waitSettle();
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 4 && n < 300) begin
      @(negedge clk);
      n++;
      if (busy) quiet = 0;
      else quiet++;
    end
    checkOutput("settle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int b0;
    int t0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_addr", {29'd0, wbus.w_addr}, 32'd0);
    checkOutput("rst_wr_en", {31'd0, wbus.w_wr_en}, 32'd0);
    checkOutput("rst_wr_data", {28'd0, wbus.w_wr_data}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_tick", {31'd0, tick}, 32'd0);
    rst_n   = 1'b1;
    ena     = 1'b1;
    learnEn = 1'b1;
    for (int i = 0; i < 8; i++) setWeight(3'(i), 4'd8);

    // LTP/LTD split: inputs 0 and 2 live
    base = wrAddr.size();
    b0   = busyCnt;
    applyTickSpikes(8'b0000_0101);
    passTicks(1);
    applyStimulus();
    waitSettle();
    checkOutput("split_count", wrAddr.size() - base, 32'd8);
    checkOutput("split_busy", busyCnt - b0, 32'd16);
    if (wrCyc.size() > base) checkOutput("split_latency", wrCyc[base] - postCyc, 32'd3);
    for (int i = 0; i < 8; i++) begin
      if (wrAddr.size() > base + i) begin
        checkOutput($sformatf("split_addr%0d", i), {29'd0, wrAddr[base+i]}, i);
        checkOutput($sformatf("split_data%0d", i), {28'd0, wrData[base+i]},
                    (i == 0 || i == 2) ? 32'd9 : 32'd7);
      end
    end

    // Saturation at both ends
    setWeight(3'd0, 4'd15);
    setWeight(3'd1, 4'd0);
    base = wrAddr.size();
    applyTickSpikes(8'b0000_0001);
    applyStimulus();
    waitSettle();
    checkOutput("sat_count", wrAddr.size() - base, 32'd8);
    if (wrAddr.size() > base + 1) begin
      checkOutput("sat_hi", {28'd0, wrData[base]}, 32'd15);
      checkOutput("sat_lo", {28'd0, wrData[base+1]}, 32'd0);
    end

    // Trace decay: six ticks leaves trace3 at 1, seven at 0
    setWeight(3'd3, 4'd8);
    base = wrAddr.size();
    applyTickSpikes(8'b0000_1000);
    passTicks(6);
    applyStimulus();
    waitSettle();
    if (wrAddr.size() > base + 3) begin
      checkOutput("decay6_addr", {29'd0, wrAddr[base+3]}, 32'd3);
      checkOutput("decay6_data", {28'd0, wrData[base+3]}, 32'd9);
    end
    setWeight(3'd3, 4'd8);
    base = wrAddr.size();
    applyTickSpikes(8'b0000_1000);
    passTicks(7);
    applyStimulus();
    waitSettle();
    if (wrAddr.size() > base + 3) begin
      checkOutput("decay7_data", {28'd0, wrData[base+3]}, 32'd7);
    end

    // Coalesced post spikes during one sweep
    base = wrAddr.size();
    b0   = busyCnt;
    applyStimulus();
    repeat (3) begin
      repeat (3) @(negedge clk);
      applyStimulus();
    end
    waitSettle();
    checkOutput("coalesce_writes", wrAddr.size() - base, 32'd16);
    checkOutput("coalesce_busy", busyCnt - b0, 32'd32);

    // learn_en gating keeps the request pending
    learnEn = 1'b0;
    base = wrAddr.size();
    applyStimulus();
    repeat (30) @(negedge clk);
    checkOutput("gate_writes", wrAddr.size() - base, 32'd0);
    checkOutput("gate_busy", {31'd0, busy}, 32'd0);
    learnEn = 1'b1;
    waitSettle();
    checkOutput("gate_release", wrAddr.size() - base, 32'd8);

    // ena=0 freezes the tick and the traces
    setWeight(3'd5, 4'd8);
    applyTickSpikes(8'b0010_0000);
    ena = 1'b0;
    t0  = tickCnt;
    repeat (40) @(negedge clk);
    checkOutput("ena_tick", tickCnt - t0, 32'd0);
    ena  = 1'b1;
    base = wrAddr.size();
    applyStimulus();
    waitSettle();
    if (wrAddr.size() > base + 5) begin
      checkOutput("ena_hold", {28'd0, wrData[base+5]}, 32'd9);
    end

    // Reset in the middle of a write cycle
    applyStimulus();
    repeat (6) @(negedge clk);
    checkOutput("mid_wr_en_pre", {31'd0, wbus.w_wr_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_wr_en", {31'd0, wbus.w_wr_en}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_addr", {29'd0, wbus.w_addr}, 32'd0);
    checkOutput("mid_rst_data", {28'd0, wbus.w_wr_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = wrAddr.size();
    repeat (40) @(negedge clk);
    checkOutput("post_rst_writes", wrAddr.size() - base, 32'd0);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
